vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_controller.sv | 140 ++++++++++++++
 tb/tb_vend_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Vending machine controller: collects coins, dispenses one product, and returns change
// or refunds the credit. Every output is registered.
module vend_controller #(
    parameter logic [4:0]  PRICE_1        = 5'd5,
    parameter logic [4:0]  PRICE_2        = 5'd10,
    parameter logic [4:0]  PRICE_3        = 5'd15,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [4:0] coin_value,
    input  logic [1:0] product_sel,
    input  logic       cancel,
    input  logic       dispense_ack,
    output logic [2:0] state,
    output logic [4:0] amount,
    output logic       dispense_req,
    output logic [1:0] product_out,
    output logic       change_valid,
    output logic [4:0] change_out,
    output logic       coin_reject,
    output logic       insufficient
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_DISPENSE = 3'd2,
        S_CHANGE   = 3'd3,
        S_REFUND   = 3'd4
    } state_t;

    localparam logic [15:0] TIMER_LAST = TIMEOUT_CYCLES - 16'd1;

    state_t      cur;
    logic [15:0] timer;
    logic [4:0]  price;

    assign state = cur;

    function automatic logic [4:0] price_of(input logic [1:0] sel);
        case (sel)
            2'b01:   price_of = PRICE_1;
            2'b10:   price_of = PRICE_2;
            2'b11:   price_of = PRICE_3;
            default: price_of = 5'd0;
        endcase
    endfunction

    // True when the coin can be credited without overflowing the 5-bit total.
    function automatic logic coin_fits(input logic [4:0] total, input logic [4:0] coin);
        logic [5:0] sum;
        sum = {1'b0, total} + {1'b0, coin};
        coin_fits = (sum <= 6'd31);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cur          <= S_IDLE;
            amount       <= 5'd0;
            timer        <= 16'd0;
            price        <= 5'd0;
            dispense_req <= 1'b0;
            product_out  <= 2'b00;
            change_valid <= 1'b0;
            change_out   <= 5'd0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
        end else begin
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            case (cur)
                S_IDLE: begin
                    if (coin_valid) begin
                        amount <= coin_value;
                        timer  <= 16'd0;
                        cur    <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (cancel) begin
                        coin_reject  <= coin_valid;
                        change_valid <= 1'b1;
                        change_out   <= amount;
                        cur          <= S_REFUND;
                    end else if (coin_valid) begin
                        if (coin_fits(amount, coin_value)) begin
                            amount <= amount + coin_value;
                            timer  <= 16'd0;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end else if (product_sel != 2'b00 && amount >= price_of(product_sel)) begin
                        price        <= price_of(product_sel);
                        product_out  <= product_sel;
                        dispense_req <= 1'b1;
                        cur          <= S_DISPENSE;
                    end else begin
                        // An under-funded request still counts as an idle cycle for the timeout.
                        insufficient <= (product_sel != 2'b00);
                        if (timer == TIMER_LAST) begin
                            change_valid <= 1'b1;
                            change_out   <= amount;
                            cur          <= S_REFUND;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                S_DISPENSE: begin
                    coin_reject <= coin_valid;
                    if (dispense_ack) begin
                        dispense_req <= 1'b0;
                        product_out  <= 2'b00;
                        if (amount > price) begin
                            change_valid <= 1'b1;
                            change_out   <= amount - price;
                            cur          <= S_CHANGE;
                        end else begin
                            amount <= 5'd0;
                            cur    <= S_IDLE;
                        end
                    end
                end
                S_CHANGE, S_REFUND: begin
                    coin_reject <= coin_valid;
                    amount      <= 5'd0;
                    timer       <= 16'd0;
                    cur         <= S_IDLE;
                end
                default: begin
                    cur <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the vending rules.
module tb_vend_controller;

    localparam int TIMEOUT = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [4:0] coin_value;
    logic [1:0] product_sel;
    logic       cancel;
    logic       dispense_ack;
    logic [2:0] state;
    logic [4:0] amount;
    logic       dispense_req;
    logic [1:0] product_out;
    logic       change_valid;
    logic [4:0] change_out;
    logic       coin_reject;
    logic       insufficient;

    int n_chk = 0;
    int n_err = 0;

    // Model state: phase uses the published state numbering; credit in whole units.
    int m_phase, m_credit, m_idle, m_price;
    int e_req, e_prod, e_cv, e_co, e_rej, e_ins;

    vend_controller dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
        .product_sel(product_sel), .cancel(cancel), .dispense_ack(dispense_ack),
        .state(state), .amount(amount), .dispense_req(dispense_req),
        .product_out(product_out), .change_valid(change_valid), .change_out(change_out),
        .coin_reject(coin_reject), .insufficient(insufficient)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic give_back(input int v);
        e_cv    = 1;
        e_co    = v;
        m_phase = 4;
    endtask

    // Prices are 5 units per product code step (5, 10, 15).
    task automatic model_step();
        int coin;
        int cost;
        coin  = int'(coin_value);
        cost  = 5 * int'(product_sel);
        e_cv  = 0;
        e_rej = 0;
        e_ins = 0;
        if (rst) begin
            m_phase = 0; m_credit = 0; m_idle = 0;
            e_req = 0; e_prod = 0; e_co = 0;
            return;
        end
        case (m_phase)
            0: if (coin_valid) begin
                m_credit = coin; m_idle = 0; m_phase = 1;
            end
            1: begin
                if (cancel) begin
                    e_rej = int'(coin_valid);
                    give_back(m_credit);
                end else if (coin_valid) begin
                    if (m_credit + coin <= 31) begin
                        m_credit += coin; m_idle = 0;
                    end else e_rej = 1;
                end else if (product_sel != 0 && m_credit >= cost) begin
                    m_price = cost; e_prod = int'(product_sel); e_req = 1; m_phase = 2;
                end else begin
                    e_ins = int'(product_sel != 0);
                    m_idle++;
                    if (m_idle == TIMEOUT) give_back(m_credit);
                end
            end
            2: begin
                e_rej = int'(coin_valid);
                if (dispense_ack) begin
                    e_req = 0; e_prod = 0;
                    if (m_credit > m_price) begin
                        e_cv = 1; e_co = m_credit - m_price; m_phase = 3;
                    end else begin
                        m_credit = 0; m_phase = 0;
                    end
                end
            end
            default: begin
                e_rej = int'(coin_valid);
                m_credit = 0; m_phase = 0;
            end
        endcase
    endtask

    task automatic step(input logic r, input logic cv, input logic [4:0] val,
                        input logic [1:0] sel, input logic cc, input logic ack);
        logic [18:0] act_v, exp_v;
        rst = r; coin_valid = cv; coin_value = val; product_sel = sel;
        cancel = cc; dispense_ack = ack;
        model_step();
        @(posedge clk);
        #1;
        exp_v = {3'(m_phase), 5'(m_credit), 1'(e_req), (e_req != 0) ? 2'(e_prod) : 2'd0,
                 1'(e_cv), (e_cv != 0) ? 5'(e_co) : 5'd0, 1'(e_rej), 1'(e_ins)};
        act_v = {state, amount, dispense_req, (e_req != 0) ? product_out : 2'd0,
                 change_valid, (e_cv != 0) ? change_out : 5'd0, coin_reject, insufficient};
        chk("cycle_outputs", 32'(act_v), 32'(exp_v));
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        m_phase = 0; m_credit = 0; m_idle = 0; m_price = 0;
        e_req = 0; e_prod = 0; e_cv = 0; e_co = 0; e_rej = 0; e_ins = 0;
        rst = 1'b1; coin_valid = 1'b0; coin_value = 5'd0; product_sel = 2'd0;
        cancel = 1'b0; dispense_ack = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd7, 2'd1, 1'b1, 1'b1);
        chk("reset_state", state, 0);
        chk("reset_amount", amount, 0);
        chk("reset_pulses", {dispense_req, change_valid, coin_reject, insufficient}, 0);

        // Coins 10, 10, select product 2, ack -> change 10
        step(1'b0, 1'b1, 5'd10, 2'd0, 1'b0, 1'b0);
        chk("idle_coin_state", state, 1);
        step(1'b0, 1'b1, 5'd10, 2'd0, 1'b0, 1'b0);
        chk("two_coins_amount", amount, 20);
        step(1'b0, 1'b0, 5'd0, 2'd2, 1'b0, 1'b0);
        chk("sel_dispense_state", state, 2);
        chk("sel_product_out", product_out, 2);
        chk("sel_dispense_req", dispense_req, 1);
        step(1'b0, 1'b1, 5'd5, 2'd1, 1'b1, 1'b0);
        chk("dispense_coin_reject", coin_reject, 1);
        chk("dispense_hold_req", dispense_req, 1);
        step(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1);
        chk("change_state", state, 3);
        chk("change_out", change_out, 10);
        chk("change_valid", change_valid, 1);
        idle_step();
        chk("after_change_state", state, 0);
        chk("after_change_amount", amount, 0);
        chk("change_pulse_width", change_valid, 0);

        // Coin 5, product 3 under-funded
        step(1'b0, 1'b1, 5'd5, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 2'd3, 1'b0, 1'b0);
        chk("insufficient_pulse", insufficient, 1);
        chk("insufficient_state", state, 1);
        chk("insufficient_amount", amount, 5);

        // Coins 20 + 10 = 30 with 5 already present: cancel to clear first
        step(1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0);
        chk("cancel_refund", change_out, 5);
        idle_step();
        step(1'b0, 1'b1, 5'd20, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd10, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd5, 2'd0, 1'b0, 1'b0);
        chk("overflow_reject", coin_reject, 1);
        chk("overflow_amount", amount, 30);
        idle_step();
        chk("reject_pulse_width", coin_reject, 0);

        // Cancel with a coin in the same cycle
        step(1'b0, 1'b1, 5'd1, 2'd1, 1'b1, 1'b0);
        chk("cancel_coin_reject", coin_reject, 1);
        chk("cancel_state", state, 4);
        chk("cancel_change_out", change_out, 30);
        idle_step();
        chk("refund_to_idle", state, 0);

        // Timeout: coin 10 then silence
        step(1'b0, 1'b1, 5'd10, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) idle_step();
        chk("timeout_not_yet", state, 1);
        idle_step();
        chk("timeout_refund_state", state, 4);
        chk("timeout_refund_value", change_out, 10);
        idle_step();
        chk("timeout_idle", state, 0);

        // Reset while dispensing
        step(1'b0, 1'b1, 5'd5, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 2'd1, 1'b0, 1'b0);
        chk("pre_reset_req", dispense_req, 1);
        step(1'b1, 1'b1, 5'd3, 2'd0, 1'b0, 1'b1);
        chk("mid_dispense_reset_state", state, 0);
        chk("mid_dispense_reset_req", dispense_req, 0);
        chk("mid_dispense_reset_amount", amount, 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            logic       r, cv, cc, ack;
            logic [4:0] val;
            logic [1:0] sel;
            r   = ($urandom_range(0, 199) == 0);
            cv  = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 3))
                0:       val = 5'd5;
                1:       val = 5'd10;
                2:       val = 5'd20;
                default: val = 5'($urandom_range(0, 31));
            endcase
            sel = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            cc  = ($urandom_range(0, 39) == 0);
            ack = ($urandom_range(0, 9) < 4);
            step(r, cv, val, sel, cc, ack);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
